// File: rtl/prt_scaler_lbf_mc.sv
// Multi-channel scaler line buffer: one block-RAM FIFO for all colour channels,
// read-paced by the timing generator, with ready threshold, sticky flags and test patterns.
module prt_scaler_lbf_mc #(
  parameter int unsigned P_PPC       = 4,
  parameter int unsigned P_BPC       = 8,
  parameter int unsigned P_CH        = 3,
  parameter int unsigned P_FIFO_WRDS = 2048,
  parameter int unsigned P_TP_CW     = 8,
  localparam int unsigned ADR = $clog2(P_FIFO_WRDS),
  localparam int unsigned DW  = P_CH * P_PPC * P_BPC
) (
  input  logic          CLK_IN,
  input  logic          RST_N_IN,
  input  logic          CTL_RUN_IN,
  input  logic          CTL_FS_IN,
  input  logic          CTL_TP_IN,
  input  logic [1:0]    CTL_TP_MODE_IN,
  input  logic [ADR:0]  CTL_LINE_WRDS_IN,
  input  logic          TG_VS_IN,
  input  logic          TG_HS_IN,
  input  logic          TG_DE_IN,
  output logic          TG_RUN_OUT,
  output logic          LBF_RDY_OUT,
  output logic          LBF_OVF_OUT,
  output logic          LBF_UDF_OUT,
  output logic [ADR:0]  LBF_WRDS_OUT,
  input  logic [DW-1:0] VID_DAT_IN,
  input  logic          VID_DE_IN,
  output logic          VID_VS_OUT,
  output logic          VID_HS_OUT,
  output logic [DW-1:0] VID_DAT_OUT,
  output logic          VID_DE_OUT
);

  typedef enum logic [1:0] {
    TP_BARS     = 2'd0,
    TP_RAMP     = 2'd1,
    TP_GREY     = 2'd2,
    TP_BARS_ALT = 2'd3
  } tp_mode_t;

  localparam logic [ADR:0]     DEPTH       = P_FIFO_WRDS[ADR:0];
  localparam logic [P_BPC-1:0] TP_H        = P_BPC'(180 << (P_BPC - 8));
  localparam logic [P_BPC-1:0] TP_L        = P_BPC'(16 << (P_BPC - 8));
  localparam logic [P_BPC-1:0] TP_GREY_LVL = P_BPC'(128 << (P_BPC - 8));

  logic     run, fs, tp;
  tp_mode_t mode;

  logic [ADR:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, wrds, wrds_q, room;
  logic         full, empty, wr_req, we, rd_act, re, line_ok;
  logic         ovf, udf, tg_run, rdy;
  logic         rd_req, de_s2, rd_zero, de_q;
  logic [2:0]   vs_d, hs_d;

  logic [DW-1:0]      mem [P_FIFO_WRDS];
  logic [DW-1:0]      ram_q, dat_q, tp_word;
  logic [P_TP_CW-1:0] tp_cnt;
  logic [2:0]         bar;
  logic [P_BPC-1:0]   pix;
  logic               bar_hi;
  int unsigned        ramp;

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      run  <= 1'b0;
      fs   <= 1'b0;
      tp   <= 1'b0;
      mode <= TP_BARS;
    end else begin
      run  <= CTL_RUN_IN;
      fs   <= CTL_FS_IN;
      tp   <= CTL_TP_IN;
      mode <= tp_mode_t'(CTL_TP_MODE_IN);
    end
  end

  assign wrds    = wr_ptr - rd_ptr;
  assign full    = (wrds == DEPTH);
  assign empty   = (wrds == '0);
  assign wr_req  = VID_DE_IN && run && !fs;
  assign we      = wr_req && !full;
  assign rd_act  = rd_req && run && !fs;
  assign re      = rd_act && !empty;
  assign line_ok = (CTL_LINE_WRDS_IN <= DEPTH);
  assign room    = DEPTH - CTL_LINE_WRDS_IN;

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (!run || fs) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (we) wr_nxt = wr_ptr + 1'b1;
      if (re) rd_nxt = rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wrds_q <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      tg_run <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      wrds_q <= wr_nxt - rd_nxt;
      rdy    <= run && line_ok && (wrds <= room);
      if (!run || fs) begin
        ovf    <= 1'b0;
        udf    <= 1'b0;
        tg_run <= 1'b0;
      end else begin
        if (wr_req && full)  ovf    <= 1'b1;
        if (rd_act && empty) udf    <= 1'b1;
        if (wrds != '0)      tg_run <= 1'b1;
      end
    end
  end

  // RAM kept free of reset so it maps onto block RAM
  always_ff @(posedge CLK_IN) begin
    if (we) mem[wr_ptr[ADR-1:0]] <= VID_DAT_IN;
    if (re) ram_q <= mem[rd_ptr[ADR-1:0]];
  end

  always_comb begin
    tp_word = '0;
    bar     = tp_cnt[P_TP_CW-1 -: 3];
    pix     = '0;
    bar_hi  = 1'b0;
    ramp    = 0;
    for (int unsigned c = 0; c < P_CH; c++) begin
      case (c % 3)
        0:       bar_hi = !bar[1];
        1:       bar_hi = !bar[2];
        default: bar_hi = !bar[0];
      endcase
      for (int unsigned p = 0; p < P_PPC; p++) begin
        ramp = 32'(tp_cnt) * P_PPC + p;
        case (mode)
          TP_RAMP: pix = P_BPC'(ramp);
          TP_GREY: pix = TP_GREY_LVL;
          default: pix = bar_hi ? TP_H : TP_L;
        endcase
        tp_word[(c * P_PPC + p) * P_BPC +: P_BPC] = pix;
      end
    end
  end

  // DE latency is fixed at three stages; an empty FIFO only zeroes the data
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      rd_req  <= 1'b0;
      de_s2   <= 1'b0;
      rd_zero <= 1'b0;
      de_q    <= 1'b0;
      dat_q   <= '0;
      tp_cnt  <= '0;
      vs_d    <= '0;
      hs_d    <= '0;
    end else begin
      rd_req  <= TG_DE_IN;
      de_s2   <= rd_req && run;
      rd_zero <= !re;
      de_q    <= de_s2 && run;
      vs_d    <= {vs_d[1:0], TG_VS_IN};
      hs_d    <= {hs_d[1:0], TG_HS_IN};
      if (!run || !de_s2) begin
        dat_q  <= '0;
        tp_cnt <= '0;
      end else begin
        if (tp)           dat_q <= tp_word;
        else if (rd_zero) dat_q <= '0;
        else              dat_q <= ram_q;
        if (tp_cnt != '1) tp_cnt <= tp_cnt + 1'b1;
      end
    end
  end

  assign TG_RUN_OUT   = tg_run & run;
  assign LBF_RDY_OUT  = rdy & run;
  assign LBF_OVF_OUT  = ovf & run;
  assign LBF_UDF_OUT  = udf & run;
  assign LBF_WRDS_OUT = wrds_q;
  assign VID_VS_OUT   = vs_d[2];
  assign VID_HS_OUT   = hs_d[2];
  assign VID_DE_OUT   = de_q & run;
  assign VID_DAT_OUT  = run ? dat_q : '0;

endmodule

// File: tb/tb_prt_scaler_lbf_mc.sv
// Directed bench for prt_scaler_lbf_mc: FIFO scoreboard, delay model, ready table
// and hand-computed test-pattern spot values.
module tb_prt_scaler_lbf_mc;

  localparam int DEPTH = 2048;
  localparam int AW    = 12;
  localparam int DW    = 96;

  logic          CLK_IN = 1'b0;
  logic          RST_N_IN;
  logic          CTL_RUN_IN, CTL_FS_IN, CTL_TP_IN;
  logic [1:0]    CTL_TP_MODE_IN;
  logic [AW-1:0] CTL_LINE_WRDS_IN;
  logic          TG_VS_IN, TG_HS_IN, TG_DE_IN;
  logic          TG_RUN_OUT, LBF_RDY_OUT, LBF_OVF_OUT, LBF_UDF_OUT;
  logic [AW-1:0] LBF_WRDS_OUT;
  logic [DW-1:0] VID_DAT_IN, VID_DAT_OUT;
  logic          VID_DE_IN, VID_VS_OUT, VID_HS_OUT, VID_DE_OUT;

  prt_scaler_lbf_mc #(
    .P_PPC(4), .P_BPC(8), .P_CH(3), .P_FIFO_WRDS(2048), .P_TP_CW(8)
  ) dut (
    .CLK_IN(CLK_IN), .RST_N_IN(RST_N_IN),
    .CTL_RUN_IN(CTL_RUN_IN), .CTL_FS_IN(CTL_FS_IN), .CTL_TP_IN(CTL_TP_IN),
    .CTL_TP_MODE_IN(CTL_TP_MODE_IN), .CTL_LINE_WRDS_IN(CTL_LINE_WRDS_IN),
    .TG_VS_IN(TG_VS_IN), .TG_HS_IN(TG_HS_IN), .TG_DE_IN(TG_DE_IN),
    .TG_RUN_OUT(TG_RUN_OUT), .LBF_RDY_OUT(LBF_RDY_OUT), .LBF_OVF_OUT(LBF_OVF_OUT),
    .LBF_UDF_OUT(LBF_UDF_OUT), .LBF_WRDS_OUT(LBF_WRDS_OUT),
    .VID_DAT_IN(VID_DAT_IN), .VID_DE_IN(VID_DE_IN),
    .VID_VS_OUT(VID_VS_OUT), .VID_HS_OUT(VID_HS_OUT),
    .VID_DAT_OUT(VID_DAT_OUT), .VID_DE_OUT(VID_DE_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct { int line; int fill; bit rdy; } rdy_vec_t;
  typedef struct { int mode; int idx; int ch; int pix; int val; } tp_vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] cap [256];
  logic [2:0]    h = '0;
  int            de_idx = 0;
  bit            tp_m = 0;
  int            mode_m = 0;
  bit            m_ovf = 0, m_udf = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  function automatic logic [DW-1:0] wd(input int i);
    return {32'(i) ^ 32'hA5A5_0000, 32'(i * 3), 32'(i)};
  endfunction

  function automatic logic [DW-1:0] tp_model(input int mode, input int idx);
    logic [DW-1:0] r;
    int v;
    bit hi;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      hi = ((idx / 64) % 2) == 0;
      else if (c == 1) hi = idx < 128;
      else             hi = ((idx / 32) % 2) == 0;
      for (int p = 0; p < 4; p++) begin
        if (mode == 1)      v = (idx * 4 + p) % 256;
        else if (mode == 2) v = 128;
        else                v = hi ? 180 : 16;
        r[(c * 4 + p) * 8 +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  task automatic cycle(input logic tde, input logic wde, input logic [DW-1:0] wdat);
    logic [DW-1:0] exp;
    TG_DE_IN   = tde;
    VID_DE_IN  = wde;
    VID_DAT_IN = wdat;
    if (wde) begin
      if (mq.size() < DEPTH) mq.push_back(wdat);
      else m_ovf = 1;
    end
    h = {h[1:0], tde};
    tick();
    check("de_out", VID_DE_OUT, h[2]);
    if (h[2]) begin
      if (mq.size() > 0) exp = mq.pop_front();
      else begin
        exp = '0;
        m_udf = 1;
      end
      if (tp_m) exp = tp_model(mode_m, de_idx);
      check("dat_out", VID_DAT_OUT, exp);
      cap[de_idx] = VID_DAT_OUT;
      if (de_idx < 255) de_idx++;
    end else begin
      de_idx = 0;
    end
  endtask

  task automatic fs_pulse();
    CTL_FS_IN = 1'b1;
    cycle(1'b0, 1'b0, '0);
    CTL_FS_IN = 1'b0;
    cycle(1'b0, 1'b0, '0);
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic tp_spot(input int mode, input tp_vec_t tv[12]);
    logic [DW-1:0] w;
    for (int k = 0; k < 12; k++) begin
      if (tv[k].mode == mode) begin
        w = cap[tv[k].idx];
        check($sformatf("tp_m%0d_w%0d_c%0d_p%0d", mode, tv[k].idx, tv[k].ch, tv[k].pix),
              w[(tv[k].ch * 4 + tv[k].pix) * 8 +: 8], 128'(tv[k].val));
      end
    end
  endtask

  rdy_vec_t rv[9];
  tp_vec_t  tv[12];
  int       nwr;

  initial begin
    rv[0] = '{960, 1088, 1};  rv[1] = '{960, 1089, 0};  rv[2] = '{959, 1089, 1};
    rv[3] = '{2049, 1089, 0}; rv[4] = '{0, 1089, 1};    rv[5] = '{2048, 1089, 0};
    rv[6] = '{1, 2047, 1};    rv[7] = '{1, 2048, 0};    rv[8] = '{0, 2048, 1};
    tv[0]  = '{0, 0, 0, 0, 180};   tv[1]  = '{0, 64, 0, 0, 16};
    tv[2]  = '{0, 128, 0, 1, 180}; tv[3]  = '{0, 200, 0, 3, 16};
    tv[4]  = '{0, 100, 1, 0, 180}; tv[5]  = '{0, 130, 1, 2, 16};
    tv[6]  = '{0, 40, 2, 0, 16};   tv[7]  = '{0, 0, 2, 2, 180};
    tv[8]  = '{1, 3, 0, 0, 12};    tv[9]  = '{1, 3, 0, 3, 15};
    tv[10] = '{1, 70, 1, 2, 26};   tv[11] = '{2, 5, 1, 3, 128};

    RST_N_IN = 1'b0;
    CTL_RUN_IN = 1'b0; CTL_FS_IN = 1'b0; CTL_TP_IN = 1'b0; CTL_TP_MODE_IN = 2'd0;
    CTL_LINE_WRDS_IN = 12'd960;
    TG_VS_IN = 1'b0; TG_HS_IN = 1'b0; TG_DE_IN = 1'b0;
    VID_DE_IN = 1'b0; VID_DAT_IN = '0;
    repeat (3) tick();
    check("rst_tg_run", TG_RUN_OUT, 0);
    check("rst_rdy", LBF_RDY_OUT, 0);
    check("rst_ovf", LBF_OVF_OUT, 0);
    check("rst_udf", LBF_UDF_OUT, 0);
    check("rst_wrds", LBF_WRDS_OUT, 0);
    check("rst_vs_hs", {VID_VS_OUT, VID_HS_OUT}, 0);
    check("rst_de", VID_DE_OUT, 0);
    check("rst_dat", VID_DAT_OUT, 0);

    // idle with toggling inputs: only the sync delay line is live
    RST_N_IN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      TG_DE_IN = i[0];
      VID_DE_IN = 1'b1;
      VID_DAT_IN = wd(i);
      TG_VS_IN = (i == 0);
      TG_HS_IN = (i == 2);
      tick();
      check("idle_vs", VID_VS_OUT, i == 2);
      check("idle_hs", VID_HS_OUT, i == 4);
      check("idle_de", VID_DE_OUT, 0);
      check("idle_dat", VID_DAT_OUT, 0);
      check("idle_wrds", LBF_WRDS_OUT, 0);
      check("idle_rdy_run", {LBF_RDY_OUT, TG_RUN_OUT}, 0);
    end
    TG_DE_IN = 1'b0; VID_DE_IN = 1'b0; TG_VS_IN = 1'b0; TG_HS_IN = 1'b0;
    repeat (3) tick();

    // basic line of 960 words
    CTL_RUN_IN = 1'b1;
    cycle(1'b0, 1'b0, '0);
    fs_pulse();
    check("line_tg_run_before", TG_RUN_OUT, 0);
    for (int i = 0; i < 960; i++) cycle(1'b0, 1'b1, wd(i));
    cycle(1'b0, 1'b0, '0);
    check("line_wrds_full", LBF_WRDS_OUT, 960);
    check("line_tg_run", TG_RUN_OUT, 1);
    check("line_rdy", LBF_RDY_OUT, 1);
    for (int i = 0; i < 960; i++) cycle(1'b1, 1'b0, '0);
    drain();
    check("line_wrds_empty", LBF_WRDS_OUT, 0);
    check("line_ovf", LBF_OVF_OUT, 0);
    check("line_udf", LBF_UDF_OUT, 0);
    check("line_tg_run_sticky", TG_RUN_OUT, 1);

    // ready threshold table
    fs_pulse();
    nwr = 0;
    for (int k = 0; k < 9; k++) begin
      while (nwr < rv[k].fill) begin
        cycle(1'b0, 1'b1, wd(nwr));
        nwr++;
      end
      CTL_LINE_WRDS_IN = 12'(rv[k].line);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      check($sformatf("rdy_line%0d_fill%0d", rv[k].line, rv[k].fill), LBF_RDY_OUT, rv[k].rdy);
      check($sformatf("rdy_wrds%0d", rv[k].fill), LBF_WRDS_OUT, rv[k].fill);
    end

    // overflow then underflow
    cycle(1'b0, 1'b1, wd(9000));
    cycle(1'b0, 1'b1, wd(9001));
    cycle(1'b0, 1'b0, '0);
    check("ovf_wrds", LBF_WRDS_OUT, 2048);
    check("ovf_flag", LBF_OVF_OUT, 1);
    check("ovf_model", m_ovf, 1);
    check("ovf_udf_clear", LBF_UDF_OUT, 0);
    for (int i = 0; i < 2049; i++) cycle(1'b1, 1'b0, '0);
    drain();
    check("udf_last_word", cap[255], 0);
    check("udf_flag", LBF_UDF_OUT, 1);
    check("udf_model", m_udf, 1);
    check("udf_wrds", LBF_WRDS_OUT, 0);
    check("udf_ovf_sticky", LBF_OVF_OUT, 1);
    fs_pulse();
    check("fs_ovf", LBF_OVF_OUT, 0);
    check("fs_udf", LBF_UDF_OUT, 0);
    check("fs_wrds", LBF_WRDS_OUT, 0);
    check("fs_tg_run", TG_RUN_OUT, 0);

    // simultaneous read/write at 100 words, streaming past the pointer wrap
    CTL_LINE_WRDS_IN = 12'd960;
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, wd(20000 + i));
    check("rw_wrds_start", LBF_WRDS_OUT, 100);
    for (int i = 0; i < 5000; i++) begin
      cycle(1'b1, 1'b1, wd(20100 + i));
      if (i == 2500) check("rw_wrds_steady", LBF_WRDS_OUT, 101);
    end
    drain();
    check("rw_wrds_end", LBF_WRDS_OUT, 100);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, '0);
    drain();
    check("wrap_wrds_empty", LBF_WRDS_OUT, 0);
    check("wrap_udf", LBF_UDF_OUT, 0);
    check("wrap_ovf", LBF_OVF_OUT, 0);

    // test patterns, one DE run per mode
    for (int m = 0; m < 4; m++) begin
      CTL_TP_IN = 1'b1;
      CTL_TP_MODE_IN = 2'(m);
      tp_m = 1;
      mode_m = m;
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      for (int i = 0; i < ((m == 0) ? 256 : (m == 1) ? 80 : 8); i++) cycle(1'b1, 1'b0, '0);
      drain();
      tp_spot(m, tv);
    end
    CTL_TP_IN = 1'b0;
    tp_m = 0;

    // run dropped mid-line
    fs_pulse();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, wd(30000 + i));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);
    CTL_RUN_IN = 1'b0;
    tick();
    check("drop_de", VID_DE_OUT, 0);
    check("drop_dat", VID_DAT_OUT, 0);
    tick();
    check("drop_wrds", LBF_WRDS_OUT, 0);
    check("drop_tg_run", TG_RUN_OUT, 0);
    check("drop_rdy", LBF_RDY_OUT, 0);
    check("drop_de2", VID_DE_OUT, 0);
    TG_DE_IN = 1'b0;
    repeat (3) tick();
    mq.delete();
    h = '0;
    de_idx = 0;
    m_ovf = 0;
    m_udf = 0;
    CTL_RUN_IN = 1'b1;
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, wd(40000 + i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    drain();
    check("restart_wrds", LBF_WRDS_OUT, 0);
    check("restart_flags", {LBF_OVF_OUT, LBF_UDF_OUT}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prt_scaler_lbf_mc.md
Name: prt_scaler_lbf_mc

Overview:
Multi-channel line buffer for the scaler datapath, successor to the per-component line buffer. A single instance buffers all colour channels of an input line stream in one inferred block-RAM FIFO, with parametric depth, channel count and pixels per clock. Output reads are paced by the scaler timing generator. The block adds a programmable ready threshold, sticky overflow/underflow flags, a fill-level output and a multi-mode test-pattern generator.

Parameters:
P_PPC, 4, pixels per clock
P_BPC, 8, bits per component; must be >= 8
P_CH, 3, colour channels; channel c uses colour index c mod 3 (0 red, 1 green, 2 blue)
P_FIFO_WRDS, 2048, FIFO depth in words; power of two
P_TP_CW, 8, test-pattern word-counter width; must be >= 3
Derived: ADR = clog2(P_FIFO_WRDS); DW = P_CH*P_PPC*P_BPC

Ports:
CLK_IN  in  1  clock
RST_N_IN  in  1  reset, asynchronous, active-low
CTL_RUN_IN  in  1  run; low = idle and flush
CTL_FS_IN  in  1  frame start; one-cycle pulse
CTL_TP_IN  in  1  test-pattern enable
CTL_TP_MODE_IN  in  2  0 bars, 1 ramp, 2 grey, 3 = bars
CTL_LINE_WRDS_IN  in  ADR+1  words per input line
TG_VS_IN  in  1  vsync
TG_HS_IN  in  1  hsync
TG_DE_IN  in  1  data enable; acts as read request
TG_RUN_OUT  out  1  timing generator run
LBF_RDY_OUT  out  1  room for one more line
LBF_OVF_OUT  out  1  sticky overflow
LBF_UDF_OUT  out  1  sticky underflow
LBF_WRDS_OUT  out  ADR+1  FIFO fill level
VID_DAT_IN  in  DW  input data
VID_DE_IN  in  1  input data enable
VID_VS_OUT  out  1  vsync, delayed
VID_HS_OUT  out  1  hsync, delayed
VID_DAT_OUT  out  DW  output data
VID_DE_OUT  out  1  output data enable

Behaviour:
- Data layout: channel c at bits [c*P_PPC*P_BPC +: P_PPC*P_BPC]; pixel p within a channel at [p*P_BPC +: P_BPC].
- Reset: every output is 0. FIFO pointers, flags, pipelines and counters are 0.
- Control register stage: CTL_RUN_IN, CTL_FS_IN, CTL_TP_IN and CTL_TP_MODE_IN are registered once (run/fs/tp/mode). All logic below uses the registered versions.
- Idle (run = 0): pointers are held at 0. RDY, TG_RUN, OVF, UDF, DE_OUT and DAT_OUT are forced to 0. Writes and reads are ignored. VS/HS still propagate through the delay line.
- Frame start (fs = 1): clears pointers, WRDS, OVF, UDF and TG_RUN. A write or read in the same cycle is ignored.
- Write: occurs when VID_DE_IN = 1, run = 1, fs = 0 and the FIFO is not full (WRDS < P_FIFO_WRDS). A write while full drops the word and sets OVF.
- Read pipeline:
  - Stage 1: rd_req = registered TG_DE_IN.
  - Stage 2: the RAM is read when rd_req = 1 and the FIFO is not empty. rd_req while empty sets UDF, does not move the pointer, and substitutes a zero word.
  - Stage 3: output register.
  - Result: VID_DE_OUT follows TG_DE_IN with 3 cycles latency, independent of FIFO state.
- Sync alignment: TG_VS_IN and TG_HS_IN pass through 3-stage delays so they stay aligned with DE.
- Fill level: WRDS = wr_ptr - rd_ptr, ADR+1 bits, with pointers ADR+1 bits wide and wrapping. A simultaneous read and write leaves WRDS unchanged. A full FIFO reads as P_FIFO_WRDS. LBF_WRDS_OUT is registered.
- Ready: registered. RDY = run && (CTL_LINE_WRDS_IN <= P_FIFO_WRDS) && (WRDS <= P_FIFO_WRDS - CTL_LINE_WRDS_IN).
- TG_RUN: set when run = 1 and WRDS != 0. Stays high until run = 0 or fs.
- Test pattern: the word index cnt (P_TP_CW bits) is 0 on the first DE_OUT word of each DE run and increments per word. It saturates at all-ones and clears when DE is low. With tp = 1 the pattern replaces DAT_OUT; DE and syncs are unaffected.
  - Definitions: S = P_BPC-8; H = 180<<S; L = 16<<S; b = cnt[P_TP_CW-1 -: 3].
  - Mode 0/3 (bars): red = H when b[1] = 0; green = H when b[2] = 0; blue = H when b[0] = 0; otherwise L. This gives white, yellow, cyan, green, magenta, red, blue, black. All pixels of the word carry the bar value.
  - Mode 1 (ramp): pixel p = (cnt*P_PPC + p) mod 2^P_BPC, same value on all channels.
  - Mode 2 (grey): all pixels = 128<<S.
  - tp or mode changes take effect on the next output word.
- Run dropped mid-line: FIFO flushes on the next cycle. DE_OUT is forced low from that cycle on; in-flight words are discarded.

Test Plan:
- Reset / idle: RST_N_IN low, then high with run = 0 and inputs toggling -> all outputs 0; VS/HS show a 3-cycle delay.
- Basic line: run = 1, fs, write 960 words (value = index), then assert TG_DE for 960 cycles after TG_RUN rises -> DE_OUT lags TG_DE by 3 cycles; data 0..959 in order; WRDS returns to 0; no flags.
- Ready threshold: depth 2048, CTL_LINE_WRDS_IN = 960 -> RDY = 1 at WRDS = 1088, 0 at WRDS = 1089; RDY = 0 when CTL_LINE_WRDS_IN = 2049.
- Overflow / underflow: 2050 writes with no reads -> WRDS = 2048 and OVF = 1. Then 2049 reads -> last word 0 and UDF = 1. fs clears both flags and WRDS.
- Simultaneous read and write at WRDS = 100 -> WRDS stays 100. Pointer wrap after 5000 streamed words keeps data intact.
- Test pattern: tp = 1, mode 0, 256-word DE run -> ch0 pixels are H for words 0-63 and 128-191, L elsewhere. Mode 1, word 3, P_PPC = 4 -> pixels 12, 13, 14, 15.
